state_sequencer: RTL and testbench

- Control-unit stage directly upstream of the instruction decoder.
- Owns the 12-bit micro-step `state` register: R → fetch F0–F2 → opcode-dependent execute steps (MOV0, LD0–LD4, ST0–ST4, HALT) → back to F0.
- Consumes the decoder's `end_sq` and `pause_cc`.
- Also provides the datapath clock enable, run/step/resume control for the monitor, and cycle and instruction counters.

---
 rtl/state_sequencer.sv | 132 +++++++++++++
 tb/tb_state_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// state_sequencer: micro-step sequencer in front of the instruction decoder.
// Walks R -> F0..F2 -> opcode-specific execute steps -> F0, supplies the
// datapath clock enable, handles pause/resume and keeps cycle/instruction
// counters.
module state_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             resume,
  input  logic [7:0]       rd,
  input  logic             end_sq,
  input  logic             pause_cc,
  output logic [11:0]      state,
  output logic             cke,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // {group[3:0], onehot_step[7:0]}
  localparam logic [11:0] S_R    = 12'h000;
  localparam logic [11:0] S_F0   = 12'h101;
  localparam logic [11:0] S_F1   = 12'h102;
  localparam logic [11:0] S_F2   = 12'h104;
  localparam logic [11:0] S_MOV0 = 12'h201;
  localparam logic [11:0] S_LD0  = 12'h301;
  localparam logic [11:0] S_LD1  = 12'h302;
  localparam logic [11:0] S_LD2  = 12'h304;
  localparam logic [11:0] S_LD3  = 12'h308;
  localparam logic [11:0] S_LD4  = 12'h310;
  localparam logic [11:0] S_ST0  = 12'h401;
  localparam logic [11:0] S_ST1  = 12'h402;
  localparam logic [11:0] S_ST2  = 12'h404;
  localparam logic [11:0] S_ST3  = 12'h408;
  localparam logic [11:0] S_ST4  = 12'h410;
  localparam logic [11:0] S_HALT = 12'hF01;

  logic        adv;
  logic [11:0] state_nxt;
  logic        halted_nxt;
  logic        illegal_nxt;
  logic        opcode_undef;

  // Only the four defined opcode groups avoid the illegal flag.
  assign opcode_undef = !(rd[7:4] inside {4'h1, 4'h2, 4'h3, 4'hF});

  // Advance request, masked while paused.
  assign adv = (run | step) & ~halted;

  // State and status registers; they follow the next-state logic every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_R;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state   <= state_nxt;
      halted  <= halted_nxt;
      illegal <= illegal_nxt;
    end
  end

  // Next micro-step and pause/illegal status; holds unless advancing or resuming.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_nxt   = state;
    halted_nxt  = halted;
    illegal_nxt = illegal;
    if (halted) begin
      if (resume) begin
        state_nxt   = S_F0;
        halted_nxt  = 1'b0;
        illegal_nxt = 1'b0;
      end
    end else if (adv) begin
      if (pause_cc) begin
        halted_nxt = 1'b1;
      end else begin
        unique case (state)
          S_R:  state_nxt = S_F0;
          S_F0: state_nxt = S_F1;
          S_F1: state_nxt = S_F2;
          S_F2: begin
            unique case (rd[7:4])
              4'h1:    state_nxt = S_MOV0;
              4'h2:    state_nxt = S_LD0;
              4'h3:    state_nxt = S_ST0;
              4'hF:    state_nxt = S_HALT;
              default: state_nxt = S_HALT;
            endcase
            if (opcode_undef) illegal_nxt = 1'b1;
          end
          S_LD0: state_nxt = S_LD1;
          S_LD1: state_nxt = S_LD2;
          S_LD2: state_nxt = S_LD3;
          S_LD3: state_nxt = S_LD4;
          S_ST0: state_nxt = S_ST1;
          S_ST1: state_nxt = S_ST2;
          S_ST2: state_nxt = S_ST3;
          S_ST3: state_nxt = S_ST4;
          // Terminal steps wait for the decoder to flag the end of the instruction.
          S_MOV0, S_LD4, S_ST4, S_HALT: begin
            if (end_sq) state_nxt = S_F0;
          end
          default: state_nxt = S_R;
        endcase
      end
    end
  end

  // Datapath enable is the advance qualifier itself.
  always_comb begin
    cke = adv;
  end

  // Free-running counters, frozen whenever the sequencer does not advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (adv) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (end_sq && !pause_cc) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer: expected next states are queued as
// each stimulus cycle is driven and compared once the clock edge has passed.
module tb_state_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             run, step, resume;
  logic [7:0]       rd;
  logic             end_sq, pause_cc;
  logic [11:0]      state;
  logic             cke, halted, illegal;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];

  state_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .resume(resume), .rd(rd),
    .end_sq(end_sq), .pause_cc(pause_cc), .state(state), .cke(cke),
    .halted(halted), .illegal(illegal), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decoder stand-in: end of instruction on terminal steps, pause in HALT.
  task automatic decode_inputs();
    end_sq   = (state == 12'h201) || (state == 12'h310) || (state == 12'h410);
    pause_cc = (state == 12'hF01);
  endtask

  // One stimulus cycle: drive, check cke before the edge, check state after.
  task automatic apply(input string tag, input logic r, input logic s,
                       input logic res, input logic [7:0] b,
                       input logic exp_cke, input logic [11:0] exp_state);
    run = r; step = s; resume = res; rd = b;
    decode_inputs();
    exp_q.push_back(exp_state);
    #1;
    check({tag, "_cke"}, {31'd0, cke}, {31'd0, exp_cke});
    @(posedge clk); #1;
    check({tag, "_state"}, {20'd0, state}, {20'd0, exp_q.pop_front()});
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0; rd = 8'h00;
    end_sq = 1'b0; pause_cc = 1'b0;
    #2;
    check("rst_state",   {20'd0, state}, 32'h000);
    check("rst_halted",  {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_cycle",   {16'd0, cycle_cnt}, 32'd0);
    check("rst_instr",   {16'd0, instr_cnt}, 32'd0);
    check("rst_cke",     {31'd0, cke}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MOV A,B
    apply("mov_f0", 1, 0, 0, 8'h16, 1, 12'h101);
    apply("mov_f1", 1, 0, 0, 8'h16, 1, 12'h102);
    apply("mov_f2", 1, 0, 0, 8'h16, 1, 12'h104);
    apply("mov_x0", 1, 0, 0, 8'h16, 1, 12'h201);
    apply("mov_end", 1, 0, 0, 8'h16, 1, 12'h101);
    check("mov_instr", {16'd0, instr_cnt}, 32'd1);
    check("mov_cycle", {16'd0, cycle_cnt}, 32'd5);

    // LD, 0x21
    apply("ld_f1", 1, 0, 0, 8'h21, 1, 12'h102);
    apply("ld_f2", 1, 0, 0, 8'h21, 1, 12'h104);
    apply("ld_0", 1, 0, 0, 8'h21, 1, 12'h301);
    apply("ld_1", 1, 0, 0, 8'h21, 1, 12'h302);
    apply("ld_2", 1, 0, 0, 8'h21, 1, 12'h304);
    apply("ld_3", 1, 0, 0, 8'h21, 1, 12'h308);
    apply("ld_4", 1, 0, 0, 8'h21, 1, 12'h310);
    check("ld_instr_pre", {16'd0, instr_cnt}, 32'd1);
    apply("ld_end", 1, 0, 0, 8'h21, 1, 12'h101);
    check("ld_instr_post", {16'd0, instr_cnt}, 32'd2);
    check("ld_cycle", {16'd0, cycle_cnt}, 32'd13);

    // Single-stepping from R
    do_reset();
    apply("st_idle0", 0, 0, 0, 8'h16, 0, 12'h000);
    apply("st_step1", 0, 1, 0, 8'h16, 1, 12'h101);
    apply("st_idle1", 0, 0, 0, 8'h16, 0, 12'h101);
    apply("st_step2", 0, 1, 0, 8'h16, 1, 12'h102);
    apply("st_idle2", 0, 0, 0, 8'h16, 0, 12'h102);
    apply("st_step3", 0, 1, 0, 8'h16, 1, 12'h104);
    check("st_cycle", {16'd0, cycle_cnt}, 32'd3);

    // HALT opcode, pause, freeze, resume
    apply("halt_enter", 1, 0, 0, 8'hF0, 1, 12'hF01);
    apply("halt_pause", 1, 0, 0, 8'hF0, 1, 12'hF01);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_illegal", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 20; i++) apply("halt_hold", 1, 0, 0, 8'hF0, 0, 12'hF01);
    check("halt_cycle_frz", {16'd0, cycle_cnt}, 32'd5);
    check("halt_instr_frz", {16'd0, instr_cnt}, 32'd0);
    apply("halt_resume", 1, 1, 1, 8'hF0, 0, 12'h101);
    check("halt_released", {31'd0, halted}, 32'd0);
    apply("halt_after", 1, 0, 0, 8'hF0, 1, 12'h102);
    check("halt_cycle_run", {16'd0, cycle_cnt}, 32'd6);

    // Undefined opcode
    apply("ill_f2", 1, 0, 0, 8'h70, 1, 12'h104);
    apply("ill_enter", 1, 0, 0, 8'h70, 1, 12'hF01);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    apply("ill_pause", 1, 0, 0, 8'h70, 1, 12'hF01);
    check("ill_halted", {31'd0, halted}, 32'd1);
    apply("ill_resume", 0, 0, 1, 8'h70, 0, 12'h101);
    check("ill_cleared", {31'd0, illegal}, 32'd0);
    check("ill_unhalted", {31'd0, halted}, 32'd0);

    // Counter wrap, then async reset in the middle of LD2
    do_reset();
    run = 1'b1; step = 1'b0; resume = 1'b0; rd = 8'h16;
    for (int i = 0; i < 65535; i++) begin
      decode_inputs();
      @(posedge clk); #1;
    end
    check("wrap_full", {16'd0, cycle_cnt}, 32'hFFFF);
    decode_inputs();
    @(posedge clk); #1;
    check("wrap_zero", {16'd0, cycle_cnt}, 32'd0);
    rd = 8'h21;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      decode_inputs();
      @(posedge clk); #1;
      if (state == 12'h304) found = 1'b1;
    end
    check("reach_ld2", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_state", {20'd0, state}, 32'h000);
    check("async_cycle", {16'd0, cycle_cnt}, 32'd0);
    check("async_instr", {16'd0, instr_cnt}, 32'd0);
    #2 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
